// File: rtl/ring_phase_monitor_pkg.sv
// Shared types and pattern helpers for the ring phase monitor and later display stages.
// Helpers take a MAX_W-wide pattern plus the live ring width so one copy serves any WIDTH.
package ring_pkg;

  localparam int MAX_W     = 32;
  localparam int IDX_MAX_W = 5;

  typedef enum logic [1:0] {
    ST_SEEK   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_FAULT  = 2'b10
  } state_t;

  function automatic logic is_onehot(input logic [MAX_W-1:0] pat);
    return ($countones(pat) == 1);
  endfunction

  // OR-encoder: exact for one-hot input, which is the only case callers trust.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_W-1:0] pat);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (pat[i]) idx = idx | i[IDX_MAX_W-1:0];
    end
    return idx;
  endfunction

  // Expected successor of a ring pattern; dir=0 moves bit i to i+1 with MSB wrapping to LSB.
  function automatic logic [MAX_W-1:0] rotate_next(input logic [MAX_W-1:0] pat,
                                                   input logic dir, input int width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] p;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    p    = pat & mask;
    if (!dir) return ((p << 1) | (p >> (width - 1))) & mask;
    else      return ((p >> 1) | (p << (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Bundle between the ring driver side and the phase monitor.
// slave is the monitor's view; master is the view of whoever drives the ring and reads status.
interface ring_phase_monitor_if #(
  parameter int WIDTH = 4,
  parameter int REV_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] count_in;
  logic             clear;
  logic [IDX_W-1:0] phase_idx;
  logic             phase_valid;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             illegal;
  logic             resync_req;
  logic [1:0]       state;

  modport slave (
    input  count_in, clear,
    output phase_idx, phase_valid, rev_tick, rev_count, illegal, resync_req, state
  );

  modport master (
    output count_in, clear,
    input  phase_idx, phase_valid, rev_tick, rev_count, illegal, resync_req, state
  );

endinterface

// File: rtl/ring_phase_monitor_onehot_decoder.sv
// Combinational one-hot to binary decoder; valid only when exactly one bit is set.
module onehot_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         i_pat,
  output logic [$clog2(WIDTH)-1:0] o_idx,
  output logic                     o_valid
);

  logic [MAX_W-1:0]     w_pat_ext;
  logic [IDX_MAX_W-1:0] w_idx_full;
  logic                 w_unused_idx;

  assign w_pat_ext    = MAX_W'(i_pat);
  assign w_idx_full   = onehot_to_idx(w_pat_ext);
  assign o_idx        = w_idx_full[$clog2(WIDTH)-1:0];
  assign o_valid      = is_onehot(w_pat_ext);
  assign w_unused_idx = ^w_idx_full;

endmodule

// File: rtl/ring_phase_monitor.sv
// Phase monitor for a one-hot ring: decodes the phase, polices rotation, counts revolutions.
// Outputs lag count_in by two edges: one to capture the sample, one to register its verdict.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEEK   | waiting for the first one-hot sample; junk is ignored
//   ST_LOCKED | each sample must hold or step once in DIR from the last legal one
//   ST_FAULT  | ERR_LIMIT consecutive illegal samples; resync requested until clear
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int REV_W     = 8,
  parameter int ERR_LIMIT = 3,
  parameter bit DIR       = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  ring_phase_monitor_if.slave bus
);

  localparam int         IDX_W     = $clog2(WIDTH);
  localparam logic [3:0] ERR_LIM_C = 4'(ERR_LIMIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_ref;
  logic [3:0]       r_err_cnt;
  logic [IDX_W-1:0] r_phase_idx;
  logic             r_phase_valid;
  logic             r_rev_tick;
  logic [REV_W-1:0] r_rev_count;
  logic             r_illegal;

  logic [WIDTH-1:0] w_ref_nxt;
  logic [3:0]       w_err_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_pv_nxt;
  logic             w_tick_nxt;
  logic [REV_W-1:0] w_rev_nxt;
  logic             w_ill_nxt;

  logic [IDX_W-1:0] w_cur_idx;
  logic             w_cur_onehot;
  logic [MAX_W-1:0] w_rot;
  logic             w_hold;
  logic             w_step;
  logic             w_legal;
  logic             w_wrap;
  logic [3:0]       w_err_inc;
  logic             w_err_full;

  onehot_decoder #(.WIDTH(WIDTH)) u_dec (
    .i_pat   (r_cur),
    .o_idx   (w_cur_idx),
    .o_valid (w_cur_onehot)
  );

  // r_ref only advances on legal samples, so a glitch never becomes the new reference.
  assign w_rot      = rotate_next(MAX_W'(r_ref), DIR, WIDTH);
  assign w_hold     = w_cur_onehot && (r_cur == r_ref);
  assign w_step     = w_cur_onehot && (MAX_W'(r_cur) == w_rot);
  assign w_legal    = w_hold || w_step;
  assign w_wrap     = w_step && (DIR ? r_ref[0] : r_ref[WIDTH-1]);
  assign w_err_inc  = r_err_cnt + 4'd1;
  assign w_err_full = (w_err_inc >= ERR_LIM_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_SEEK;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_SEEK;
    end else begin
      case (r_state)
        ST_SEEK:   if (w_cur_onehot) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (!w_legal && w_err_full) w_state_nxt = ST_FAULT;
        ST_FAULT:  w_state_nxt = ST_FAULT;
        default:   w_state_nxt = ST_SEEK;
      endcase
    end
  end

  always_comb begin
    w_ref_nxt  = r_ref;
    w_err_nxt  = r_err_cnt;
    w_idx_nxt  = r_phase_idx;
    w_pv_nxt   = 1'b0;
    w_tick_nxt = 1'b0;
    w_rev_nxt  = r_rev_count;
    w_ill_nxt  = 1'b0;
    if (bus.clear) begin
      w_ref_nxt = r_cur;
      w_err_nxt = '0;
      w_rev_nxt = '0;
    end else begin
      case (r_state)
        ST_SEEK: begin
          w_ref_nxt = r_cur;
          w_err_nxt = '0;
          if (w_cur_onehot) w_idx_nxt = w_cur_idx;
        end
        ST_LOCKED: begin
          if (w_legal) begin
            w_ref_nxt = r_cur;
            w_err_nxt = '0;
            w_idx_nxt = w_cur_idx;
            w_pv_nxt  = 1'b1;
            if (w_wrap) begin
              w_tick_nxt = 1'b1;
              w_rev_nxt  = r_rev_count + REV_W'(1);
            end
          end else begin
            w_ill_nxt = 1'b1;
            w_err_nxt = w_err_inc;
          end
        end
        default: begin
          w_ref_nxt = r_cur;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur         <= '0;
      r_ref         <= '0;
      r_err_cnt     <= '0;
      r_phase_idx   <= '0;
      r_phase_valid <= 1'b0;
      r_rev_tick    <= 1'b0;
      r_rev_count   <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_cur         <= bus.count_in;
      r_ref         <= w_ref_nxt;
      r_err_cnt     <= w_err_nxt;
      r_phase_idx   <= w_idx_nxt;
      r_phase_valid <= w_pv_nxt;
      r_rev_tick    <= w_tick_nxt;
      r_rev_count   <= w_rev_nxt;
      r_illegal     <= w_ill_nxt;
    end
  end

  assign bus.phase_idx   = r_phase_idx;
  assign bus.phase_valid = r_phase_valid;
  assign bus.rev_tick    = r_rev_tick;
  assign bus.rev_count   = r_rev_count;
  assign bus.illegal     = r_illegal;
  assign bus.resync_req  = (r_state == ST_FAULT);
  assign bus.state       = r_state;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed plus random bench for ring_phase_monitor against an index-arithmetic reference model.
module tb_ring_phase_monitor;

  localparam int W   = 4;
  localparam int RW  = 8;
  localparam int LIM = 3;
  localparam bit DIR = 1'b0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ring_phase_monitor_if #(.WIDTH(W), .REV_W(RW)) bus ();

  ring_phase_monitor #(.WIDTH(W), .REV_W(RW), .ERR_LIMIT(LIM), .DIR(DIR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // reference model: phase as an integer index, rotation as modular index arithmetic
  int         m_state, m_err, m_idx, m_rev;
  bit         m_pv, m_tick, m_ill;
  logic [3:0] m_cur, m_ref;

  function automatic int idx_of(input logic [3:0] p);
    for (int i = 0; i < W; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_err = 0; m_idx = 0; m_rev = 0;
    m_pv = 0; m_tick = 0; m_ill = 0; m_cur = '0; m_ref = '0;
  endtask

  task automatic model_edge(input logic [3:0] p, input bit c);
    int ci, ri, nx;
    m_tick = 0; m_ill = 0;
    if (c) begin
      m_state = 0; m_err = 0; m_rev = 0; m_pv = 0;
    end else if (m_state == 0) begin
      m_pv = 0;
      if ($countones(m_cur) == 1) begin
        m_state = 1; m_idx = idx_of(m_cur); m_ref = m_cur; m_err = 0;
      end
    end else if (m_state == 1) begin
      ci = idx_of(m_cur);
      ri = idx_of(m_ref);
      nx = (ri + (DIR ? W - 1 : 1)) % W;
      if ($countones(m_cur) == 1 && (ci == ri || ci == nx)) begin
        m_pv = 1; m_idx = ci; m_err = 0;
        if (ci == nx && nx == (DIR ? W - 1 : 0)) begin
          m_tick = 1;
          m_rev  = (m_rev + 1) % (1 << RW);
        end
        m_ref = m_cur;
      end else begin
        m_ill = 1; m_pv = 0; m_err++;
        if (m_err >= LIM) m_state = 2;
      end
    end else begin
      m_pv = 0;
    end
    m_cur = p;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(bus.state),       32'(m_state));
    chk({tag, ".pvalid"}, 32'(bus.phase_valid), 32'(m_pv));
    chk({tag, ".pidx"},   32'(bus.phase_idx),   32'(m_idx));
    chk({tag, ".illegal"},32'(bus.illegal),     32'(m_ill));
    chk({tag, ".tick"},   32'(bus.rev_tick),    32'(m_tick));
    chk({tag, ".revcnt"}, 32'(bus.rev_count),   32'(m_rev));
    chk({tag, ".resync"}, 32'(bus.resync_req),  32'(m_state == 2));
  endtask

  task automatic step(input logic [3:0] p, input bit c, input string tag);
    @(negedge clk);
    bus.count_in = p;
    bus.clear    = c;
    @(posedge clk);
    model_edge(p, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] d;
    int         r;
    bit         c;
    int         n_ticks;

    bus.count_in = '0;
    bus.clear    = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: one full revolution
    step(4'b0001, 0, "t1"); step(4'b0010, 0, "t1"); step(4'b0100, 0, "t1");
    step(4'b1000, 0, "t1"); step(4'b0001, 0, "t1"); step(4'b0001, 0, "t1");
    chk("t1.revcnt_final", 32'(bus.rev_count), 32'd1);
    chk("t1.state_final",  32'(bus.state),     32'd1);

    // 2: single multi-hot glitch while locked
    step(4'b0010, 0, "t2"); step(4'b0010, 0, "t2"); step(4'b0110, 0, "t2");
    step(4'b0100, 0, "t2"); step(4'b0100, 0, "t2"); step(4'b0100, 0, "t2");
    chk("t2.state_final", 32'(bus.state), 32'd1);

    // 3: persistent all-zero forces FAULT; legal input afterwards is ignored
    step(4'b0000, 0, "t3"); step(4'b0000, 0, "t3"); step(4'b0000, 0, "t3");
    step(4'b1000, 0, "t3"); step(4'b0001, 0, "t3"); step(4'b0010, 0, "t3");
    step(4'b0100, 0, "t3");
    chk("t3.state_final",  32'(bus.state),      32'd2);
    chk("t3.resync_final", 32'(bus.resync_req), 32'd1);
    chk("t3.revcnt_final", 32'(bus.rev_count),  32'd1);

    // 4: clear out of FAULT, relock at phase 3
    step(4'b1000, 1, "t4");
    chk("t4.state_seek", 32'(bus.state), 32'd0);
    step(4'b1000, 0, "t4"); step(4'b1000, 0, "t4");
    chk("t4.pidx_final",   32'(bus.phase_idx), 32'd3);
    chk("t4.revcnt_final", 32'(bus.rev_count), 32'd0);

    // 5: skip and reverse steps, then a long hold
    step(4'b0001, 0, "t5"); step(4'b0100, 0, "t5"); step(4'b0010, 0, "t5");
    step(4'b0100, 0, "t5"); step(4'b0010, 0, "t5"); step(4'b0100, 0, "t5");
    step(4'b1000, 0, "t5"); step(4'b0001, 0, "t5");
    repeat (5) step(4'b0001, 0, "t5hold");

    // 6: 256 revolutions wrap the counter back to zero
    step(4'b0001, 1, "t6"); step(4'b0001, 0, "t6");
    n_ticks = 0;
    for (int rv = 0; rv < 256; rv++) begin
      d = 4'b0001;
      for (int k = 0; k < W; k++) begin
        d = {d[2:0], d[3]};
        step(d, 0, "t6");
        if (bus.rev_tick) n_ticks++;
      end
    end
    step(4'b0001, 0, "t6");
    if (bus.rev_tick) n_ticks++;
    chk("t6.ticks",        32'(n_ticks),       32'd256);
    chk("t6.revcnt_final", 32'(bus.rev_count), 32'd0);

    // random walk of steps, holds, corruption and clears
    d = 4'b0001;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      c = 0;
      if      (r < 45) d = {d[2:0], d[3]};
      else if (r < 65) d = d;
      else if (r < 80) d = 4'($urandom_range(0, 15));
      else if (r < 88) d = {d[0], d[3:1]};
      else if (r < 94) d = 4'b0001 << $urandom_range(0, 3);
      else             c = 1;
      step(d, c, "rnd");
    end

    // async reset while locked with a nonzero revolution count
    step(4'b0001, 1, "pre"); step(4'b0001, 0, "pre"); step(4'b0010, 0, "pre");
    step(4'b0100, 0, "pre"); step(4'b1000, 0, "pre"); step(4'b0001, 0, "pre");
    step(4'b0010, 0, "pre");
    @(posedge clk);
    model_edge(4'b0010, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    bus.count_in = '0;
    @(negedge clk);
    reset = 1'b1;
    step(4'b0100, 0, "post"); step(4'b1000, 0, "post"); step(4'b0001, 0, "post");
    step(4'b0001, 0, "post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
